dino_motion_ctrl: RTL and testbench

Sequencer for the player dinosaur. It runs the run, duck, jump, float and dead pose state machine, integrates jump physics on a slow tick, and steps the run/duck animation phase. It drives the dino sprite renderer with a registered top row and a sprite select, which replaces the ad-hoc physics that sat next to the sprite ROMs. It sits between key decode / game-over logic and the display pixel mux.

---
 rtl/dino_pkg.sv | 47 ++++
 rtl/dino_anim_phase.sv | 44 ++++
 rtl/dino_motion_ctrl.sv | 146 ++++++++++++++
 tb/tb_dino_motion_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and defaults for the player dinosaur motion sequencer and its display consumers.
package dino_pkg;

  localparam int unsigned POS_W = 9;
  localparam int unsigned V_W   = 6;
  localparam int unsigned SUM_W = 10;

  localparam int unsigned GROUND_DEF    = 300;
  localparam int unsigned FLOAT_ROW_DEF = 100;
  localparam int unsigned INIT_V_DEF    = 15;
  localparam int unsigned GRAVITY_DEF   = 1;
  localparam int unsigned ANIM_DIV_DEF  = 6;

  localparam logic [1:0] KEY_JUMP = 2'b01;
  localparam logic [1:0] KEY_DUCK = 2'b10;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DUCK  = 3'd1,
    ST_JUMP  = 3'd2,
    ST_FLOAT = 3'd3,
    ST_DEAD  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    SPR_DEFAULT = 3'd0,
    SPR_RUN_L   = 3'd1,
    SPR_RUN_R   = 3'd2,
    SPR_DUCK_L  = 3'd3,
    SPR_DUCK_R  = 3'd4,
    SPR_DEAD    = 3'd5
  } sprite_e;

  // Sprite code for a pose; airborne poses use the default sprite.
  function automatic logic [2:0] sprite_of(input state_e st, input logic phase);
    logic [2:0] s;
    s = SPR_DEFAULT;
    case (st)
      ST_RUN:  s = phase ? SPR_RUN_R : SPR_RUN_L;
      ST_DUCK: s = phase ? SPR_DUCK_R : SPR_DUCK_L;
      ST_DEAD: s = SPR_DEAD;
      default: s = SPR_DEFAULT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dino_anim_phase.sv
// Run/duck animation phase: divides anim_tick by ANIM_DIV and toggles a phase bit.
module dino_anim_phase
  import dino_pkg::*;
#(
  parameter int unsigned ANIM_DIV = ANIM_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic anim_tick,
  output logic phase_next_c
);

  localparam int unsigned CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             phase;

  always_comb begin
    cnt_n        = cnt;
    phase_next_c = phase;
    if (en && anim_tick) begin
      if (cnt == CNT_LAST) begin
        cnt_n        = '0;
        phase_next_c = ~phase;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      phase <= phase_next_c;
    end
  end

endmodule

// File: rtl/dino_motion_ctrl.sv
// Player dinosaur pose FSM with jump physics on the slow tick and a registered sprite/row output.
module dino_motion_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned GROUND    = GROUND_DEF,
  parameter int unsigned FLOAT_ROW = FLOAT_ROW_DEF,
  parameter int unsigned INIT_V    = INIT_V_DEF,
  parameter int unsigned GRAVITY   = GRAVITY_DEF,
  parameter int unsigned ANIM_DIV  = ANIM_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       anim_tick,
  input  logic [1:0] key,
  input  logic       over,
  input  logic       cheat,
  output logic [8:0] pos,
  output logic [2:0] sprite,
  output logic       jumping,
  output logic       ducking
);

  localparam logic signed [SUM_W-1:0] GROUND_S  = SUM_W'(GROUND);
  localparam logic        [POS_W-1:0] GROUND_P  = POS_W'(GROUND);
  localparam logic        [POS_W-1:0] FLOAT_P   = POS_W'(FLOAT_ROW);
  localparam logic signed [V_W-1:0]   V_LAUNCH  = -$signed(V_W'(INIT_V));
  localparam logic signed [V_W:0]     V_MAX     = (V_W+1)'((1 << (V_W - 1)) - 1);
  localparam logic signed [V_W:0]     GRAV_S    = (V_W+1)'(GRAVITY);

  state_e                  state;
  state_e                  state_n;
  logic [POS_W-1:0]        pos_n;
  logic signed [V_W-1:0]   v;
  logic signed [V_W-1:0]   v_n;
  logic                    jump_req;
  logic                    jump_req_n;
  logic signed [SUM_W-1:0] sum;
  logic signed [V_W:0]     v_inc;
  logic signed [V_W-1:0]   v_grav;
  logic                    anim_en;
  logic                    phase_next_c;

  // Signed row update; the extra bit keeps pos+v from wrapping before the ground compare.
  assign sum    = $signed({1'b0, pos}) + $signed({{(SUM_W - V_W){v[V_W-1]}}, v});
  assign v_inc  = $signed({v[V_W-1], v}) + GRAV_S;
  assign v_grav = (v_inc > V_MAX) ? V_MAX[V_W-1:0] : v_inc[V_W-1:0];

  // Counter advances only when the pose being entered animates.
  assign anim_en = (state_n == ST_RUN) || (state_n == ST_DUCK);

  dino_anim_phase #(
    .ANIM_DIV (ANIM_DIV)
  ) u_anim (
    .clk          (clk),
    .rst          (rst),
    .en           (anim_en),
    .anim_tick    (anim_tick),
    .phase_next_c (phase_next_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    pos_n      = pos;
    v_n        = v;
    jump_req_n = jump_req;
    if (over || (state == ST_DEAD)) begin
      state_n    = ST_DEAD;
      v_n        = '0;
      jump_req_n = 1'b0;
    end else if (cheat) begin
      state_n    = ST_FLOAT;
      pos_n      = FLOAT_P;
      v_n        = '0;
      jump_req_n = 1'b0;
    end else begin
      case (state)
        ST_RUN, ST_DUCK: begin
          if (key == KEY_JUMP) begin
            jump_req_n = 1'b1;
          end
          if (tick) begin
            if (jump_req) begin
              state_n    = ST_JUMP;
              v_n        = V_LAUNCH;
              jump_req_n = 1'b0;
            end else if ((state == ST_RUN) && (key == KEY_DUCK)) begin
              state_n = ST_DUCK;
            end else if ((state == ST_DUCK) && (key != KEY_DUCK)) begin
              state_n = ST_RUN;
            end
          end
        end
        ST_JUMP: begin
          jump_req_n = 1'b0;
          if (tick) begin
            if (sum >= GROUND_S) begin
              state_n = ST_RUN;
              pos_n   = GROUND_P;
              v_n     = '0;
            end else begin
              pos_n = sum[SUM_W-1] ? '0 : POS_W'(sum);
              v_n   = v_grav;
            end
          end
        end
        ST_FLOAT: begin
          state_n    = ST_JUMP;
          v_n        = '0;
          jump_req_n = 1'b0;
        end
        default: begin
          state_n    = ST_RUN;
          jump_req_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos      <= GROUND_P;
      v        <= '0;
      jump_req <= 1'b0;
      sprite   <= SPR_RUN_L;
      jumping  <= 1'b0;
      ducking  <= 1'b0;
    end else begin
      pos      <= pos_n;
      v        <= v_n;
      jump_req <= jump_req_n;
      sprite   <= sprite_of(state_n, phase_next_c);
      jumping  <= (state_n == ST_JUMP);
      ducking  <= (state_n == ST_DUCK);
    end
  end

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed bench for dino_motion_ctrl: per-cycle scoreboard from a behavioural model plus fixed-value checkpoints.
module tb_dino_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       anim_tick;
  logic [1:0] key;
  logic       over;
  logic       cheat;
  logic [8:0] pos;
  logic [2:0] sprite;
  logic       jumping;
  logic       ducking;

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  typedef struct {
    int  pos;
    int  sprite;
    bit  jumping;
    bit  ducking;
  } exp_t;

  exp_t sb[$];

  // Behavioural model: 0 run, 1 duck, 2 jump, 3 float, 4 dead
  int m_st;
  int m_pos;
  int m_v;
  int m_cnt;
  bit m_req;
  bit m_phase;

  dino_motion_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .anim_tick (anim_tick),
    .key       (key),
    .over      (over),
    .cheat     (cheat),
    .pos       (pos),
    .sprite    (sprite),
    .jumping   (jumping),
    .ducking   (ducking)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc_no, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pos = 300; m_v = 0; m_cnt = 0; m_req = 0; m_phase = 0;
  endtask

  task automatic model_step(input bit t, input bit at, input int k, input bit ov, input bit ch);
    int   nst;
    exp_t e;
    nst = m_st;
    if (ov || m_st == 4) begin
      nst = 4; m_v = 0; m_req = 0;
    end else if (ch) begin
      nst = 3; m_pos = 100; m_v = 0; m_req = 0;
    end else if (m_st == 3) begin
      nst = 2; m_v = 0;
    end else if (m_st == 2) begin
      m_req = 0;
      if (t) begin
        if (m_pos + m_v >= 300) begin
          nst = 0; m_pos = 300; m_v = 0;
        end else begin
          m_pos = m_pos + m_v; m_v = m_v + 1;
        end
      end
    end else begin
      if (t && m_req) begin
        nst = 2; m_v = -15; m_req = 0;
      end else begin
        if (k == 1) m_req = 1;
        if (t && m_st == 0 && k == 2) nst = 1;
        else if (t && m_st == 1 && k != 2) nst = 0;
      end
    end
    if (at && (nst == 0 || nst == 1)) begin
      if (m_cnt == 5) begin m_cnt = 0; m_phase = !m_phase; end
      else m_cnt++;
    end
    m_st = nst;
    e.pos     = m_pos;
    e.sprite  = (nst == 4) ? 5 : (nst == 0) ? 1 + int'(m_phase) : (nst == 1) ? 3 + int'(m_phase) : 0;
    e.jumping = (nst == 2);
    e.ducking = (nst == 1);
    sb.push_back(e);
  endtask

  // One clock: drive inputs, predict, clock, then compare against the oldest prediction.
  task automatic cyc(input bit t, input bit at, input logic [1:0] k, input bit ov = 0, input bit ch = 0);
    exp_t e;
    tick = t; anim_tick = at; key = k; over = ov; cheat = ch;
    model_step(t, at, int'(k), ov, ch);
    @(posedge clk);
    #1;
    cyc_no++;
    e = sb.pop_front();
    check("sb_pos", 32'(pos), 32'(e.pos));
    check("sb_sprite", 32'(sprite), 32'(e.sprite));
    check("sb_jumping", 32'(jumping), 32'(e.jumping));
    check("sb_ducking", 32'(ducking), 32'(e.ducking));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; anim_tick = 1'b0; key = 2'b00; over = 1'b0; cheat = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rst_pos", 32'(pos), 32'd300);
    check("rst_sprite", 32'(sprite), 32'd1);
    check("rst_jumping", 32'(jumping), 32'd0);
    check("rst_ducking", 32'(ducking), 32'd0);
  endtask

  initial begin
    int min_pos;

    // Idle run: row fixed at ground, sprite alternates every six animation steps.
    do_reset();
    for (int n = 1; n <= 100; n++) begin
      cyc(1, 1, 2'b00);
      check("idle_pos", 32'(pos), 32'd300);
      check("idle_sprite", 32'(sprite), 32'(1 + ((n / 6) % 2)));
      cyc(0, 0, 2'b00);
    end

    // Short key pulse between ticks, full jump, landing coincident with a phase wrap.
    do_reset();
    for (int n = 0; n < 5; n++) cyc(0, 1, 2'b00);
    cyc(0, 0, 2'b01);
    cyc(0, 0, 2'b00);
    cyc(0, 0, 2'b00);
    check("prelaunch_jumping", 32'(jumping), 32'd0);
    cyc(1, 0, 2'b00);
    check("launch_pos", 32'(pos), 32'd300);
    check("launch_jumping", 32'(jumping), 32'd1);
    check("launch_sprite", 32'(sprite), 32'd0);
    min_pos = 300;
    for (int s = 1; s <= 31; s++) begin
      cyc(1, 1, 2'b00);
      if (int'(pos) < min_pos) min_pos = int'(pos);
      if (s == 1)  check("jump_step1", 32'(pos), 32'd285);
      if (s == 2)  check("jump_step2", 32'(pos), 32'd271);
      if (s == 3)  check("jump_step3", 32'(pos), 32'd258);
      if (s == 15) check("jump_apex", 32'(pos), 32'd180);
      check("jump_flag", 32'(jumping), 32'(s < 31));
    end
    check("jump_min", 32'(min_pos), 32'd180);
    check("land_pos", 32'(pos), 32'd300);
    check("land_sprite_phase", 32'(sprite), 32'd2);

    // Hold duck: phase starts at 1 after the wrap above.
    for (int n = 1; n <= 12; n++) begin
      cyc(1, 1, 2'b10);
      check("duck_flag", 32'(ducking), 32'd1);
      check("duck_sprite", 32'(sprite), 32'(((n / 6) % 2) == 0 ? 4 : 3));
    end
    cyc(0, 0, 2'b01);
    check("duck_req_hold", 32'(ducking), 32'd1);
    cyc(1, 0, 2'b00);
    check("duck_jump_flag", 32'(jumping), 32'd1);
    check("duck_jump_sprite", 32'(sprite), 32'd0);
    check("duck_jump_duckflag", 32'(ducking), 32'd0);

    // Death at apex: frozen row, key presses ignored, only reset recovers.
    for (int s = 1; s <= 15; s++) cyc(1, 0, 2'b00);
    check("apex2_pos", 32'(pos), 32'd180);
    cyc(0, 0, 2'b00, 1);
    check("dead_sprite", 32'(sprite), 32'd5);
    check("dead_pos", 32'(pos), 32'd180);
    for (int i = 0; i < 50; i++) begin
      cyc(1, 1, ((i % 10) == 3) ? 2'b01 : 2'b00, (i < 10) ? 1'b1 : 1'b0);
      check("dead_hold_pos", 32'(pos), 32'd180);
      check("dead_hold_sprite", 32'(sprite), 32'd5);
    end
    do_reset();

    // Float cheat, then free fall from the float row with velocity 0,1,2,...
    cyc(1, 1, 2'b00, 0, 1);
    check("float_pos", 32'(pos), 32'd100);
    check("float_sprite", 32'(sprite), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 2'b01, 0, 1);
    cyc(0, 0, 2'b00);
    check("fall_start_pos", 32'(pos), 32'd100);
    check("fall_start_jumping", 32'(jumping), 32'd1);
    for (int n = 1; n <= 25; n++) begin
      cyc(1, 0, 2'b00);
      check("fall_pos", 32'(pos), 32'((n <= 20) ? 100 + (n * (n - 1)) / 2 : 300));
      check("fall_jumping", 32'(jumping), 32'(n <= 20));
    end
    check("fall_end_sprite", 32'(sprite), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
